multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//   Multicycle MIPS control FSM; successor to the single-cycle decoder. Sequences
//   each instruction over 3-5+ states and drives the shared-memory datapath
//   (PC, IR, A/B/ALUOut/Data registers). Adds parametrised memory wait states and
//   an illegal-opcode/funct flag. Sits between the IR fields and the datapath muxes.
// PARAMETERS
//   MEM_WAIT   0  extra wait cycles per memory access (FETCH, MEMREAD, MEMWRITE); 0..15
//   ULA_W      3  width of ULAControl; codes below are zero-extended if ULA_W>3
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      async active-high reset
//   OP          in   6      IR[31:26]
//   Funct       in   6      IR[5:0]
//   PCWrite     out  1      unconditional PC load
//   Branch      out  1      PC load if ULA Zero (datapath ANDs it)
//   IorD        out  1      0=PC addresses memory, 1=ALUOut
//   MemWrite    out  1      memory write strobe
//   IRWrite     out  1      IR load
//   RegDst      out  1      1=rd, 0=rt
//   MemtoReg    out  1      1=Data reg, 0=ALUOut to regfile
//   RegWrite    out  1      regfile write
//   ULASrcA     out  1      0=PC, 1=A
//   ULASrcB     out  2      00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
//   PCSrc       out  2      00=ULA result, 01=ALUOut, 10=jump target
//   ULAControl  out  ULA_W  010 add, 110 sub, 000 and, 001 or, 011 nor, 111 slt
//   ZeroExt     out  1      1=zero-extend immediate (0 unless IMM_LOGIC_EN)
//   IllegalOp   out  1      one-cycle pulse on unknown OP / R-type Funct
// BEHAVIOUR
//   - Clock clk, reset rst: one clock; reset is asynchronous and active-high.
//   - rst: state<=FETCH, wait counter<=0; while rst=1 every output forced 0.
//   - Outputs are Moore: decoded from state (+Funct in EXECUTE); unlisted outputs 0.
//   - Wait counter: FETCH, MEMREAD, MEMWRITE each last MEM_WAIT+1 cycles; counter
//     counts 0..MEM_WAIT, clears on state exit. IorD/ULASrc* held on all wait cycles;
//     IRWrite, PCWrite (FETCH), MemWrite only on the last cycle.
//   - FETCH: IorD=0, ULASrcA=0, ULASrcB=01, add, PCSrc=00, IRWrite=PCWrite=1 -> DECODE.
//   - DECODE: ULASrcA=0, ULASrcB=11, add (branch target). Next by OP:
//     000000->EXECUTE; 100011/101011->MEMADR; 000100->BRANCH; 001000->ADDIEXEC;
//     000010->JUMP; other->FETCH with IllegalOp=1 this cycle.
//   - MEMADR: ULASrcA=1, ULASrcB=10, add -> MEMREAD (LW) / MEMWRITE (SW).
//   - MEMREAD: IorD=1 -> MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
//   - MEMWRITE: IorD=1, MemWrite=1 (last cycle) -> FETCH.
//   - EXECUTE: ULASrcA=1, ULASrcB=00, ULAControl from Funct: 100000 add, 100010 sub,
//     100100 and, 100101 or, 100111 nor, 101010 slt -> ALUWB. Unknown Funct: add,
//     IllegalOp=1, -> FETCH (no writeback).
//   - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
//   - BRANCH: ULASrcA=1, ULASrcB=00, sub, PCSrc=01, Branch=1 -> FETCH.
//   - ADDIEXEC: ULASrcA=1, ULASrcB=10, add -> ADDIWB.
//   - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
//   - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
//   - Latency (cycles, W=MEM_WAIT): R 4+W, LW 5+2W, SW 4+2W, BEQ 3+W, ADDI 4+W, J 3+W.
//   - OP/Funct sampled only in DECODE/EXECUTE; IR stable otherwise (IRWrite=0).
//   - rst mid-instruction: abort immediately, no pending write completes.
//   - Unreachable state encodings -> FETCH next cycle, outputs 0.
// CONFIGURATION
//   IMM_LOGIC_EN defined: DECODE also accepts 001100 (ANDI) -> ANDIEXEC and
//   001101 (ORI) -> ORIEXEC: ULASrcA=1, ULASrcB=10, ZeroExt=1, ULAControl and/or
//   -> ADDIWB (shared). Latency 4+W.
//   Not defined: ANDI/ORI take the illegal path (IllegalOp pulse, ->FETCH); ZeroExt tied 0.
// TESTING
//   - W=0, OP=000000 Funct=100010 -> FETCH,DECODE,EXECUTE(ULAControl=110),ALUWB
//     (RegWrite=1,RegDst=1); IRWrite on cycle 1 only; 4 cycles.
//   - W=0, LW (100011) -> 5 states; MEMREAD IorD=1; MEMWB MemtoReg=1,RegWrite=1.
//   - W=2, LW -> 9 cycles; IRWrite and PCWrite high only on cycle 3; IorD=1 cycles 6-8.
//   - BEQ -> BRANCH at cycle 3 with Branch=1, PCSrc=01, ULAControl=110; J -> PCWrite=1,
//     PCSrc=10 at cycle 3.
//   - OP=111111 -> IllegalOp=1 in DECODE, FETCH next; OP=0 Funct=000000 -> IllegalOp in
//     EXECUTE, RegWrite never 1; ANDI checked with and without IMM_LOGIC_EN.
//   - rst asserted mid-MEMWRITE (W=3) -> MemWrite=0 at once, all outputs 0; after
//     release FETCH with IorD=0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave):
// IR opcode/funct fields in, mux selects and write strobes out.
interface multicycle_control_unit_if #(
  parameter int unsigned ULA_W = 3
);
  logic [5:0]       OP;
  logic [5:0]       Funct;
  logic             PCWrite;
  logic             Branch;
  logic             IorD;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ULASrcA;
  logic [1:0]       ULASrcB;
  logic [1:0]       PCSrc;
  logic [ULA_W-1:0] ULAControl;
  logic             ZeroExt;
  logic             IllegalOp;

  modport master (
    input  OP, Funct,
    output PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ULASrcA, ULASrcB, PCSrc, ULAControl, ZeroExt, IllegalOp
  );

  modport slave (
    output OP, Funct,
    input  PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ULASrcA, ULASrcB, PCSrc, ULAControl, ZeroExt, IllegalOp
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with parametrised memory wait states and illegal-op flag.
// Optional feature: define IMM_LOGIC_EN to decode ANDI/ORI with zero-extended immediates.
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned ULA_W    = 3
) (
  input logic                       clk,
  input logic                       rst,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    StFetch     = 4'd0,
    StDecode    = 4'd1,
    StMemAdr    = 4'd2,
    StMemRead   = 4'd3,
    StMemWb     = 4'd4,
    StMemWrite  = 4'd5,
    StExecute   = 4'd6,
    StAluWb     = 4'd7,
    StBranch    = 4'd8,
    StAddiExec  = 4'd9,
    StAddiWb    = 4'd10,
    StJump      = 4'd11,
    StAndiExec  = 4'd12,
    StOriExec   = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef IMM_LOGIC_EN
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
`endif

  localparam logic [2:0] UlaAdd = 3'b010;
  localparam logic [2:0] UlaSub = 3'b110;
  localparam logic [2:0] UlaAnd = 3'b000;
  localparam logic [2:0] UlaOr  = 3'b001;
  localparam logic [2:0] UlaNor = 3'b011;
  localparam logic [2:0] UlaSlt = 3'b111;

  localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       mem_last;

  logic       pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       src_a, zero_ext, illegal;
  logic [1:0] src_b, pc_src;
  logic [2:0] ula;

  assign mem_last = (wait_q == WaitLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    src_a      = 1'b0;
    src_b      = 2'b00;
    pc_src     = 2'b00;
    ula        = 3'b000;
    zero_ext   = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      StFetch: begin
        src_b = 2'b01;
        ula   = UlaAdd;
        if (mem_last) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StDecode: begin
        // Speculative branch target into ALUOut
        src_b = 2'b11;
        ula   = UlaAdd;
        case (bus.OP)
          OpRtype:     state_d = StExecute;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq:       state_d = StBranch;
          OpAddi:      state_d = StAddiExec;
          OpJ:         state_d = StJump;
`ifdef IMM_LOGIC_EN
          OpAndi:      state_d = StAndiExec;
          OpOri:       state_d = StOriExec;
`endif
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        ula     = UlaAdd;
        state_d = (bus.OP == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        iord = 1'b1;
        if (mem_last) state_d = StMemWb;
        else          wait_d  = wait_q + 4'd1;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        iord = 1'b1;
        if (mem_last) begin
          mem_write = 1'b1;
          state_d   = StFetch;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StExecute: begin
        src_a   = 1'b1;
        state_d = StAluWb;
        case (bus.Funct)
          6'b100000: ula = UlaAdd;
          6'b100010: ula = UlaSub;
          6'b100100: ula = UlaAnd;
          6'b100101: ula = UlaOr;
          6'b100111: ula = UlaNor;
          6'b101010: ula = UlaSlt;
          default: begin
            ula     = UlaAdd;
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        src_a   = 1'b1;
        ula     = UlaSub;
        pc_src  = 2'b01;
        branch  = 1'b1;
        state_d = StFetch;
      end
      StAddiExec: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        ula     = UlaAdd;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = StFetch;
      end
`ifdef IMM_LOGIC_EN
      StAndiExec, StOriExec: begin
        src_a    = 1'b1;
        src_b    = 2'b10;
        zero_ext = 1'b1;
        ula      = (state_q == StAndiExec) ? UlaAnd : UlaOr;
        state_d  = StAddiWb;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  // Reset blanks every output combinationally so an aborted write never strobes.
  assign bus.PCWrite    = pc_write & ~rst;
  assign bus.Branch     = branch & ~rst;
  assign bus.IorD       = iord & ~rst;
  assign bus.MemWrite   = mem_write & ~rst;
  assign bus.IRWrite    = ir_write & ~rst;
  assign bus.RegDst     = reg_dst & ~rst;
  assign bus.MemtoReg   = mem_to_reg & ~rst;
  assign bus.RegWrite   = reg_write & ~rst;
  assign bus.ULASrcA    = src_a & ~rst;
  assign bus.ULASrcB    = rst ? 2'b00 : src_b;
  assign bus.PCSrc      = rst ? 2'b00 : pc_src;
  assign bus.ULAControl = rst ? '0 : ULA_W'(ula);
  assign bus.ZeroExt    = zero_ext & ~rst;
  assign bus.IllegalOp  = illegal & ~rst;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: three control units (MEM_WAIT 0/2/3) share clock, reset and IR fields;
// each run checks one unit's packed output word cycle by cycle against hand-written words.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op_r = '0;
  logic [5:0] funct_r = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ULA_W(3)) bus0 ();
  multicycle_control_unit_if #(.ULA_W(3)) bus2 ();
  multicycle_control_unit_if #(.ULA_W(3)) bus3 ();

  assign bus0.OP = op_r;
  assign bus0.Funct = funct_r;
  assign bus2.OP = op_r;
  assign bus2.Funct = funct_r;
  assign bus3.OP = op_r;
  assign bus3.Funct = funct_r;

  multicycle_control_unit #(.MEM_WAIT(0), .ULA_W(3)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  multicycle_control_unit #(.MEM_WAIT(2), .ULA_W(3)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  multicycle_control_unit #(.MEM_WAIT(3), .ULA_W(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // {PCWrite,Branch,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ULASrcA,
  //  ULASrcB,PCSrc,ULAControl,ZeroExt,IllegalOp}
  logic [17:0] obs [3];
  assign obs[0] = {bus0.PCWrite, bus0.Branch, bus0.IorD, bus0.MemWrite, bus0.IRWrite,
                   bus0.RegDst, bus0.MemtoReg, bus0.RegWrite, bus0.ULASrcA, bus0.ULASrcB,
                   bus0.PCSrc, bus0.ULAControl, bus0.ZeroExt, bus0.IllegalOp};
  assign obs[1] = {bus2.PCWrite, bus2.Branch, bus2.IorD, bus2.MemWrite, bus2.IRWrite,
                   bus2.RegDst, bus2.MemtoReg, bus2.RegWrite, bus2.ULASrcA, bus2.ULASrcB,
                   bus2.PCSrc, bus2.ULAControl, bus2.ZeroExt, bus2.IllegalOp};
  assign obs[2] = {bus3.PCWrite, bus3.Branch, bus3.IorD, bus3.MemWrite, bus3.IRWrite,
                   bus3.RegDst, bus3.MemtoReg, bus3.RegWrite, bus3.ULASrcA, bus3.ULASrcB,
                   bus3.PCSrc, bus3.ULAControl, bus3.ZeroExt, bus3.IllegalOp};

  localparam logic [17:0] ExpZero     = 18'b0;
  localparam logic [17:0] ExpFetchW   = {9'b0_0_0_0_0_0_0_0_0, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [17:0] ExpFetch    = {9'b1_0_0_0_1_0_0_0_0, 2'b01, 2'b00, 3'b010, 2'b00};
  localparam logic [17:0] ExpDecode   = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 3'b010, 2'b00};
  localparam logic [17:0] ExpDecIll   = {9'b0_0_0_0_0_0_0_0_0, 2'b11, 2'b00, 3'b010, 2'b01};
  localparam logic [17:0] ExpMemAdr   = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 3'b010, 2'b00};
  localparam logic [17:0] ExpMemRead  = {9'b0_0_1_0_0_0_0_0_0, 9'b0};
  localparam logic [17:0] ExpMemWb    = {9'b0_0_0_0_0_0_1_1_0, 9'b0};
  localparam logic [17:0] ExpMemWrW   = {9'b0_0_1_0_0_0_0_0_0, 9'b0};
  localparam logic [17:0] ExpMemWr    = {9'b0_0_1_1_0_0_0_0_0, 9'b0};
  localparam logic [17:0] ExpExecSub  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 3'b110, 2'b00};
  localparam logic [17:0] ExpExecIll  = {9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, 3'b010, 2'b01};
  localparam logic [17:0] ExpAluWb    = {9'b0_0_0_0_0_1_0_1_0, 9'b0};
  localparam logic [17:0] ExpBranch   = {9'b0_1_0_0_0_0_0_0_1, 2'b00, 2'b01, 3'b110, 2'b00};
  localparam logic [17:0] ExpAddiWb   = {9'b0_0_0_0_0_0_0_1_0, 9'b0};
  localparam logic [17:0] ExpJump     = {9'b1_0_0_0_0_0_0_0_0, 2'b00, 2'b10, 3'b000, 2'b00};
  localparam logic [17:0] ExpAndiExec = {9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 3'b000, 2'b10};

  logic [17:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reset with the given IR fields, then compare one word per cycle from FETCH onwards.
  task automatic run_seq(input string name, input int sel, input logic [5:0] op,
                         input logic [5:0] fn);
    @(negedge clk);
    rst = 1'b1;
    op_r = op;
    funct_r = fn;
    #1 check({name, "_rst"}, 32'(obs[sel]), 32'(ExpZero));
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("%s_c%0d", name, i + 1), 32'(obs[sel]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    exp_q = '{ExpFetch, ExpDecode, ExpExecSub, ExpAluWb, ExpFetch};
    run_seq("r_sub_w0", 0, 6'b000000, 6'b100010);

    exp_q = '{ExpFetch, ExpDecode, ExpMemAdr, ExpMemRead, ExpMemWb, ExpFetch};
    run_seq("lw_w0", 0, 6'b100011, 6'b000000);

    exp_q = '{ExpFetchW, ExpFetchW, ExpFetch, ExpDecode, ExpMemAdr,
              ExpMemRead, ExpMemRead, ExpMemRead, ExpMemWb, ExpFetchW};
    run_seq("lw_w2", 1, 6'b100011, 6'b000000);

    exp_q = '{ExpFetch, ExpDecode, ExpMemAdr, ExpMemWr, ExpFetch};
    run_seq("sw_w0", 0, 6'b101011, 6'b000000);

    exp_q = '{ExpFetch, ExpDecode, ExpBranch, ExpFetch};
    run_seq("beq_w0", 0, 6'b000100, 6'b000000);

    exp_q = '{ExpFetch, ExpDecode, ExpJump, ExpFetch};
    run_seq("j_w0", 0, 6'b000010, 6'b000000);

    exp_q = '{ExpFetch, ExpDecode, ExpMemAdr, ExpAddiWb, ExpFetch};
    run_seq("addi_w0", 0, 6'b001000, 6'b000000);

    exp_q = '{ExpFetch, ExpDecIll, ExpFetch, ExpDecIll};
    run_seq("bad_op", 0, 6'b111111, 6'b000000);

    exp_q = '{ExpFetch, ExpDecode, ExpExecIll, ExpFetch, ExpDecode};
    run_seq("bad_funct", 0, 6'b000000, 6'b000000);

`ifdef IMM_LOGIC_EN
    exp_q = '{ExpFetch, ExpDecode, ExpAndiExec, ExpAddiWb, ExpFetch};
`else
    exp_q = '{ExpFetch, ExpDecIll, ExpFetch};
`endif
    run_seq("andi_w0", 0, 6'b001100, 6'b000000);

    // SW with W=3, reset lands on the second MEMWRITE wait cycle
    exp_q = '{ExpFetchW, ExpFetchW, ExpFetchW, ExpFetch, ExpDecode, ExpMemAdr,
              ExpMemWrW, ExpMemWrW};
    run_seq("sw_w3", 2, 6'b101011, 6'b000000);
    #2 rst = 1'b1;
    #1 check("sw_w3_abort", 32'(obs[2]), 32'(ExpZero));
    @(posedge clk);
    #1 check("sw_w3_abort_hold", 32'(obs[2]), 32'(ExpZero));
    @(negedge clk);
    rst = 1'b0;
    #1 check("sw_w3_restart", 32'(obs[2]), 32'(ExpFetchW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
